// File: rtl/lag_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : lag_arb_pkg
//  Purpose : Shared definitions for the arbiter requester: a counter-width
//            helper and the per-port state record (pending count and
//            starvation counter).
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package lag_arb_pkg;

  // Bits needed to hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Largest DEPTH / STARVE_LIM the per-port state record can hold. Both
  // fields share this width so one record type serves every parameterisation
  // up to this limit; the upper bits simply stay zero for small limits.
  localparam int LAG_MAX_LIM = 255;
  localparam int LAG_FW      = cnt_width(LAG_MAX_LIM);

  typedef struct packed {
    logic [LAG_FW-1:0] cnt;         // pending requests, 0..DEPTH
    logic [LAG_FW-1:0] starve_ctr;  // cycles requested without service
  } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/lag_arb_requester_if.sv
`default_nettype none
// ============================================================================
//  Module  : lag_arb_requester_if
//  Purpose : Bundles the client-push and arbiter-handshake signals of the
//            requester.
//  Signals : push[SIZE]        per-port pulse, add one pending request
//            push_ready[SIZE]  port can accept a push
//            request[SIZE]     to arbiter, port has a pending request
//            grant[SIZE]       from arbiter, one-hot or zero
//            success           grant is final this cycle
//            served[SIZE]      registered retire pulse
//            starve[SIZE]      port waited STARVE_LIM cycles unserved
//            err               sticky protocol-error flag
//  Modports: master drives push/grant/success (clients + arbiter side),
//            slave is the requester itself.
//  Rev     : 1.0  initial release
// ============================================================================
interface lag_arb_requester_if #(
  parameter int unsigned SIZE = 20
);
  logic [SIZE-1:0] push;
  logic [SIZE-1:0] push_ready;
  logic [SIZE-1:0] request;
  logic [SIZE-1:0] grant;
  logic            success;
  logic [SIZE-1:0] served;
  logic [SIZE-1:0] starve;
  logic            err;

  modport master (
    output push, grant, success,
    input  push_ready, request, served, starve, err
  );

  modport slave (
    input  push, grant, success,
    output push_ready, request, served, starve, err
  );
endinterface
`default_nettype wire

// File: rtl/lag_req_slot.sv
`default_nettype none
// ============================================================================
//  Module  : lag_req_slot
//  Purpose : One client port of the requester: pending-request counter,
//            starvation counter, registered served pulse and overflow detect.
//  Ports   : clk, rst        clock, synchronous active-high reset
//            push_i          add one pending request
//            grant_i         arbiter grant for this port
//            success_i       grant is final this cycle
//            push_ready_o    pending count below DEPTH
//            request_o       at least one request pending
//            served_o        one request retired on the previous edge
//            starve_o        starvation counter at STARVE_LIM
//            ovf_o           push dropped because the port is full (comb.)
//  Rev     : 1.0  initial release
// ============================================================================
module lag_req_slot
  import lag_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic grant_i,
  input  logic success_i,
  output logic push_ready_o,
  output logic request_o,
  output logic served_o,
  output logic starve_o,
  output logic ovf_o
);

  localparam logic [LAG_FW-1:0] C_DEPTH = LAG_FW'(DEPTH);
  localparam logic [LAG_FW-1:0] C_LIM   = LAG_FW'(STARVE_LIM);
  localparam logic [LAG_FW-1:0] C_ONE   = LAG_FW'(1);

  slot_state_t st_q, st_d;
  logic        served_q;
  logic        w_req;
  logic        w_ready;
  logic        w_ret;

  // request/push_ready come from registered state only, so grant never
  // reaches request combinationally.
  assign w_req   = (st_q.cnt != '0);
  assign w_ready = (st_q.cnt != C_DEPTH);
  assign w_ret   = grant_i & success_i & w_req;

  // A full port still accepts a push when the same cycle retires one.
  assign ovf_o   = push_i & ~w_ready & ~w_ret;

  always_comb begin
    st_d = st_q;

    if (push_i && !w_ret && w_ready) begin
      st_d.cnt = st_q.cnt + C_ONE;
    end else if (w_ret && !push_i) begin
      st_d.cnt = st_q.cnt - C_ONE;
    end

    if (w_ret || !w_req) begin
      st_d.starve_ctr = '0;
    end else if (st_q.starve_ctr != C_LIM) begin
      st_d.starve_ctr = st_q.starve_ctr + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= '0;
      served_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      served_q <= w_ret;
    end
  end

  assign push_ready_o = w_ready;
  assign request_o    = w_req;
  assign served_o     = served_q;
  assign starve_o     = (st_q.starve_ctr == C_LIM);

endmodule
`default_nettype wire

// File: rtl/lag_arb_requester.sv
`default_nettype none
// ============================================================================
//  Module  : lag_arb_requester
//  Purpose : Initiator side of the switch-allocation arbiter handshake. Keeps
//            up to DEPTH pending requests per client port, drives the request
//            vector, retires one request per successful grant and flags
//            starvation and protocol errors.
//  Ports   : clk   clock, all state on posedge
//            rst   synchronous active-high reset
//            bus   lag_arb_requester_if.slave (push/grant/success in;
//                  push_ready/request/served/starve/err out)
//  Rev     : 1.0  initial release
// ============================================================================
module lag_arb_requester
  import lag_arb_pkg::*;
#(
  parameter int unsigned SIZE       = 20,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 15
) (
  input  logic                clk,
  input  logic                rst,
  lag_arb_requester_if.slave  bus
);

  logic [SIZE-1:0] w_ready;
  logic [SIZE-1:0] w_req;
  logic [SIZE-1:0] w_served;
  logic [SIZE-1:0] w_starve;
  logic [SIZE-1:0] w_ovf;
  logic            w_multi;
  logic            w_unreq;
  logic            err_q, err_d;

  generate
    for (genvar gi = 0; gi < int'(SIZE); gi++) begin : g_slot
      lag_req_slot #(
        .DEPTH      (DEPTH),
        .STARVE_LIM (STARVE_LIM)
      ) u_slot (
        .clk          (clk),
        .rst          (rst),
        .push_i       (bus.push[gi]),
        .grant_i      (bus.grant[gi]),
        .success_i    (bus.success),
        .push_ready_o (w_ready[gi]),
        .request_o    (w_req[gi]),
        .served_o     (w_served[gi]),
        .starve_o     (w_starve[gi]),
        .ovf_o        (w_ovf[gi])
      );
    end
  endgenerate

  // More than one grant bit: clearing the lowest set bit leaves a residue.
  assign w_multi = ((bus.grant & (bus.grant - SIZE'(1))) != '0);

  // A speculative grant to an idle port is fine; only a final one is an error.
  assign w_unreq = (|(bus.grant & ~w_req)) & bus.success;

  assign err_d = err_q | w_multi | w_unreq | (|w_ovf);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.push_ready = w_ready;
  assign bus.request    = w_req;
  assign bus.served     = w_served;
  assign bus.starve     = w_starve;
  assign bus.err        = err_q;

endmodule
`default_nettype wire
